// File: rtl/uart_frame_decode.sv
// rtl/uart_frame_decode.sv - UART frame checker/decoder with FWFT output FIFO and session counters
//
// Takes the shifted-in frame word from the upstream protocol parser, checks start/stop
// (and optionally parity), extracts the LSB-first data byte and queues {byte, ferr, perr}
// for a valid/ready consumer.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   clear        - synchronous session clear (same effect as reset)
//   frame_in     - parser frame word, first received bit in the MSB
//   frame_valid  - single-cycle strobe qualifying frame_in
//   out_byte     - decoded data byte of the head entry (upper unused bits 0)
//   out_ferr     - head entry framing error
//   out_perr     - head entry parity error
//   out_valid    - head entry present
//   out_ready    - consumer accepts head entry
//   frame_cnt    - saturating count of frames this session
//   err_cnt      - saturating count of frames with ferr or perr
//   ovf          - sticky: a decoded frame was dropped on a full FIFO
//   fifo_level   - current FIFO occupancy

module uart_frame_decode #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WIDTH = DATA_BITS + 2 + PARITY_EN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [FRAME_WIDTH-1:0]        frame_in,
  input  logic                          frame_valid,
  output logic [7:0]                    out_byte,
  output logic                          out_ferr,
  output logic                          out_perr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   err_cnt,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

  // Combinational decode of the incoming frame word
  logic [7:0] dec_byte;
  logic       dec_ferr;
  logic       dec_perr;

  always_comb begin
    dec_byte = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      dec_byte[i] = frame_in[FRAME_WIDTH-2-i];
    end
    dec_ferr = frame_in[FRAME_WIDTH-1] | ~frame_in[0];
    dec_perr = 1'b0;
    if (PARITY_EN != 0) begin
      dec_perr = ((^dec_byte) ^ frame_in[1]) != PARITY_ODD[0];
    end
  end

  // Stage 1 registers
  logic [7:0] s1_byte;
  logic       s1_ferr;
  logic       s1_perr;
  logic       s1_valid;

  // FIFO storage and control
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [9:0]    wr_data;
  logic          full;
  logic          pop;
  logic          push;

  assign rd_next   = rd_ptr + 1'b1;
  assign wr_data   = {s1_byte, s1_ferr, s1_perr};
  assign full      = (fifo_level == FULL_LEVEL);
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push      = s1_valid & (~full | pop);

  // Storage array needs no reset: the head is held in registers below and the
  // pointers/level are what define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      s1_byte    <= '0;
      s1_ferr    <= 1'b0;
      s1_perr    <= 1'b0;
      s1_valid   <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      ovf        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_byte   <= '0;
      out_ferr   <= 1'b0;
      out_perr   <= 1'b0;
    end else begin
      s1_valid <= frame_valid;
      if (frame_valid) begin
        s1_byte <= dec_byte;
        s1_ferr <= dec_ferr;
        s1_perr <= dec_perr;
        if (frame_cnt != 16'hFFFF) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
        if ((dec_ferr | dec_perr) && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end

      if (s1_valid && !push) begin
        ovf <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + ONE_LEVEL;
        2'b01:   fifo_level <= fifo_level - ONE_LEVEL;
        default: fifo_level <= fifo_level;
      endcase

      // Head registers: refreshed only when the head entry changes, so they
      // hold their last value while the FIFO is empty.
      if (pop && (fifo_level > ONE_LEVEL)) begin
        {out_byte, out_ferr, out_perr} <= mem[rd_next];
      end else if (push && (fifo_level == '0 || pop)) begin
        // Empty, or level 1 with the only entry leaving: the new entry becomes head.
        {out_byte, out_ferr, out_perr} <= wr_data;
      end
    end
  end

endmodule
